// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with any depth >= 2, almost-full/empty thresholds,
// standard or first-word-fall-through read mode, and synchronous flush.
module fifo_sync_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                wr_en,
  input  logic [FIFO_WIDTH-1:0]               data_in,
  input  logic                                rd_en,
  output logic [FIFO_WIDTH-1:0]               data_out,
  output logic                                data_valid,
  output logic                                wr_ack,
  output logic                                overflow,
  output logic                                underflow,
  output logic                                full,
  output logic                                empty,
  output logic                                almostfull,
  output logic                                almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_ok, rd_ok;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almostfull  = (count_q >= AF_C);
  assign almostempty = !empty && (count_q <= AE_C);
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= !flush && wr_ok;
      overflow_q  <= !flush && wr_en && !wr_ok;
      underflow_q <= !flush && rd_en && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out   = mem_q[rd_ptr_q];
    assign data_valid = ~empty;
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  dv_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else if (flush) begin
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_ok;
        if (rd_ok) dout_q <= mem_q[rd_ptr_q];
      end
    end
    assign data_out   = dout_q;
    assign data_valid = dv_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Three FIFO variants (depth 8 std, depth 5 std, depth 8 FWFT) share one
// stimulus stream; each is compared every cycle against a list-based model.
module tb_fifo_sync_param;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] din = '0;
  logic [2:0][15:0] dout_w;
  logic [2:0] dv_w, ack_w, ovf_w, udf_w, full_w, empty_w, af_w, ae_w;
  logic [3:0] cnt0, cnt2;
  logic [2:0] cnt1;
  int checks = 0, fails = 0;

  int md[3]  = '{8, 5, 8};
  int maf[3] = '{6, 4, 6};
  int mae[3] = '{1, 1, 2};
  bit mfw[3] = '{1'b0, 1'b0, 1'b1};

  logic [15:0] mq [3][8];
  int          msz [3];
  logic [15:0] mdout [3];
  bit          mdv [3], mack [3], movf [3], mudf [3];

  always #5 clk = ~clk;

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_d8 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(din), .rd_en(rd_en),
    .data_out(dout_w[0]), .data_valid(dv_w[0]), .wr_ack(ack_w[0]), .overflow(ovf_w[0]),
    .underflow(udf_w[0]), .full(full_w[0]), .empty(empty_w[0]), .almostfull(af_w[0]),
    .almostempty(ae_w[0]), .count(cnt0));

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_d5 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(din), .rd_en(rd_en),
    .data_out(dout_w[1]), .data_valid(dv_w[1]), .wr_ack(ack_w[1]), .overflow(ovf_w[1]),
    .underflow(udf_w[1]), .full(full_w[1]), .empty(empty_w[1]), .almostfull(af_w[1]),
    .almostempty(ae_w[1]), .count(cnt1));

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(din), .rd_en(rd_en),
    .data_out(dout_w[2]), .data_valid(dv_w[2]), .wr_ack(ack_w[2]), .overflow(ovf_w[2]),
    .underflow(udf_w[2]), .full(full_w[2]), .empty(empty_w[2]), .almostfull(af_w[2]),
    .almostempty(ae_w[2]), .count(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      msz[i] = 0; mdout[i] = '0; mdv[i] = 0; mack[i] = 0; movf[i] = 0; mudf[i] = 0;
    end
  endtask

  // Model: ordered list; pop shifts the list down, push appends at the tail.
  task automatic mstep();
    for (int i = 0; i < 3; i++) begin
      bit e, rdo, wro;
      logic [15:0] popped;
      e = (msz[i] == 0);
      popped = '0;
      if (flush) begin
        msz[i] = 0; mack[i] = 0; movf[i] = 0; mudf[i] = 0; mdv[i] = 0;
      end else begin
        rdo = rd_en && !e;
        wro = wr_en && (msz[i] < md[i] || rdo);
        mack[i] = wro;
        movf[i] = wr_en && !wro;
        mudf[i] = rd_en && e;
        if (rdo) begin
          popped = mq[i][0];
          for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
          msz[i]--;
        end
        if (wro) begin
          mq[i][msz[i]] = din;
          msz[i]++;
        end
        if (!mfw[i]) begin
          mdv[i] = rdo;
          if (rdo) mdout[i] = popped;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] c[3];
    c[0] = 32'(cnt0); c[1] = 32'(cnt1); c[2] = 32'(cnt2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.count", i), c[i], 32'(msz[i]));
      chk($sformatf("u%0d.full", i), 32'(full_w[i]), 32'(msz[i] == md[i]));
      chk($sformatf("u%0d.empty", i), 32'(empty_w[i]), 32'(msz[i] == 0));
      chk($sformatf("u%0d.almostfull", i), 32'(af_w[i]), 32'(msz[i] >= maf[i]));
      chk($sformatf("u%0d.almostempty", i), 32'(ae_w[i]), 32'(msz[i] > 0 && msz[i] <= mae[i]));
      chk($sformatf("u%0d.wr_ack", i), 32'(ack_w[i]), 32'(mack[i]));
      chk($sformatf("u%0d.overflow", i), 32'(ovf_w[i]), 32'(movf[i]));
      chk($sformatf("u%0d.underflow", i), 32'(udf_w[i]), 32'(mudf[i]));
      if (mfw[i]) begin
        chk($sformatf("u%0d.data_valid", i), 32'(dv_w[i]), 32'(msz[i] > 0));
        if (msz[i] > 0) chk($sformatf("u%0d.data_out", i), 32'(dout_w[i]), 32'(mq[i][0]));
      end else begin
        chk($sformatf("u%0d.data_valid", i), 32'(dv_w[i]), 32'(mdv[i]));
        chk($sformatf("u%0d.data_out", i), 32'(dout_w[i]), 32'(mdout[i]));
      end
    end
  endtask

  task automatic cyc(input bit w, input bit r, input bit f, input logic [15:0] d);
    wr_en = w; rd_en = r; flush = f; din = d;
    @(posedge clk);
    mstep();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit did_rst;
    int wb, rb;
    did_rst = 0;
    mreset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // fill past full, then drain past empty
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 16'(16'hA0 + i));
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, '0);
    // simultaneous read/write on full, then on empty
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 16'(16'hB0 + i));
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 16'(16'hC0 + i));
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, '0);
    cyc(1, 1, 0, 16'h0077);
    cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);
    // single word into empty: FWFT shows it without a read
    cyc(1, 0, 0, 16'h0055);
    cyc(0, 0, 0, '0);
    cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);
    // interleaved traffic wraps the depth-5 pointers several times
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 16'(16'hD0 + i));
      cyc(0, 1, 0, '0);
    end
    // flush beats a same-cycle write
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'(16'hE0 + i));
    cyc(1, 0, 1, 16'h00EE);
    cyc(0, 0, 0, '0);

    for (int n = 0; n < 1200; n++) begin
      wb = ((n / 100) % 2 == 0) ? 70 : 35;
      rb = 100 - wb;
      cyc($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb,
          $urandom_range(0, 63) == 0, 16'($urandom));
      if (n >= 300 && !did_rst && msz[0] >= 3 && msz[2] >= 3) begin
        did_rst = 1;
        rst = 1'b1;
        #1;
        mreset();
        check_all();
        #1 rst = 1'b0;
      end
    end
    chk("mid_burst_reset_hit", 32'(did_rst), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
